// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button step counter.
// The debounce state encoding is common to both button channels.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button -> 2-flop sync -> debounce FSM -> registered one-cycle step pulse,
// with optional auto-repeat while the button stays held.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100_000,
  parameter int unsigned HOLD_CYCLES     = 5_000_000,
  parameter int unsigned REPEAT_CYCLES   = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic step_o
);

  localparam int unsigned CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DEB_LIM  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES - 1);
  localparam bit            DEB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic [1:0]    sync_q;
  logic          lvl;
  btn_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] hcnt_q;
  logic          rpt_q;
  logic          step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

  assign lvl    = sync_q[1];
  assign step_o = step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      rpt_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      // Repeat timer runs only while the synced level is high; a release bounce freezes it.
      if (REPEAT_EN && (state_q == HELD || state_q == RELEASE_WAIT) && lvl) begin
        if (!rpt_q && hcnt_q == HOLD_LIM) begin
          step_q <= 1'b1;
          rpt_q  <= 1'b1;
          hcnt_q <= '0;
        end else if (rpt_q && hcnt_q == REP_LIM) begin
          step_q <= 1'b1;
          hcnt_q <= '0;
        end else begin
          hcnt_q <= hcnt_q + CW'(1);
        end
      end
      case (state_q)
        RELEASED: if (lvl) begin
          if (DEB_ONE) begin
            state_q <= HELD;
            step_q  <= 1'b1;
            hcnt_q  <= '0;
            rpt_q   <= 1'b0;
          end else begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!lvl) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LIM) begin
            state_q <= HELD;
            step_q  <= 1'b1;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            rpt_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: if (!lvl) begin
          if (DEB_ONE) begin
            state_q <= RELEASED;
            hcnt_q  <= '0;
            rpt_q   <= 1'b0;
          end else begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (lvl) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LIM) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            rpt_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_step_counter.sv
// Two debounced push-buttons stepping an up/down lamp counter.
// Simultaneous up and down steps cancel; WRAP selects modulo vs saturating behaviour.
module button_step_counter
  import button_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 100_000,
  parameter int unsigned HOLD_CYCLES     = 5_000_000,
  parameter int unsigned REPEAT_CYCLES   = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          WRAP            = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic             up_step,
  output logic             down_step,
  output logic [WIDTH-1:0] lamps
);

  if (DEBOUNCE_CYCLES == 0 || HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_param
    $error("button_step_counter: cycle parameters must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] lamps_q;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
  ) u_up (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_up), .step_o(up_step)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
  ) u_down (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_down), .step_o(down_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamps_q <= '0;
    end else if (up_step && !down_step) begin
      if (WRAP || lamps_q != MAX) lamps_q <= lamps_q + WIDTH'(1);
    end else if (down_step && !up_step) begin
      if (WRAP || lamps_q != '0) lamps_q <= lamps_q - WIDTH'(1);
    end
  end

  assign lamps = lamps_q;

endmodule

// File: tb/tb_button_step_counter.sv
// Scoreboard bench: a cycle-level model of the button rules pushes expectations,
// a negedge monitor pops and compares against a wrapping and a saturating instance.
module tb_button_step_counter;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down;
  logic       up_w, dn_w, up_s, dn_s;
  logic [7:0] lamps_w, lamps_s;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic [7:0] lw;
    logic [7:0] ls;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  button_step_counter #(
    .WIDTH(8), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .REPEAT_EN(1'b1), .WRAP(1'b1)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .up_step(up_w), .down_step(dn_w), .lamps(lamps_w)
  );

  button_step_counter #(
    .WIDTH(8), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .REPEAT_EN(1'b1), .WRAP(1'b0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .up_step(up_s), .down_step(dn_s), .lamps(lamps_s)
  );

  // Reference: debounced level flips after DEB consecutive differing synced samples;
  // while held, the n-th qualifying cycle after the press steps at HOLD, HOLD+REP, ...
  initial begin : model
    bit s1[2], s2[2], deb[2], st[2], pst[2], raw[2];
    int run[2], n[2];
    int lw, ls;
    bit lvl, flip;
    lw = 0; ls = 0;
    forever begin
      @(posedge clk);
      raw[0] = btn_up;
      raw[1] = btn_down;
      if (!rst_n) begin
        for (int b = 0; b < 2; b++) begin
          s1[b] = 0; s2[b] = 0; deb[b] = 0; st[b] = 0; pst[b] = 0; run[b] = 0; n[b] = 0;
        end
        lw = 0; ls = 0;
        q.push_back('0);
      end else begin
        if (pst[0] && !pst[1]) begin
          lw = (lw + 1) % 256;
          if (ls < 255) ls++;
        end else if (pst[1] && !pst[0]) begin
          lw = (lw + 255) % 256;
          if (ls > 0) ls--;
        end
        for (int b = 0; b < 2; b++) begin
          lvl   = s2[b];
          st[b] = 0;
          flip  = 0;
          if (lvl != deb[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
              deb[b] = lvl;
              run[b] = 0;
              flip   = 1;
              if (lvl) begin
                st[b] = 1;
                n[b]  = 0;
              end
            end
          end else begin
            run[b] = 0;
          end
          if (!flip && deb[b] && lvl) begin
            n[b]++;
            if (n[b] == HOLD || (n[b] > HOLD && (n[b] - HOLD) % REP == 0)) st[b] = 1;
          end
          s2[b] = s1[b];
          s1[b] = raw[b];
        end
        q.push_back('{st[0], st[1], 8'(lw), 8'(ls)});
        pst = st;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard @%0t: got empty queue want entry", $time);
      end else begin
        e = q.pop_front();
        if (!rst_n) e = '0;
        chk("up_step_wrap",   {7'd0, up_w}, {7'd0, e.up});
        chk("down_step_wrap", {7'd0, dn_w}, {7'd0, e.dn});
        chk("up_step_sat",    {7'd0, up_s}, {7'd0, e.up});
        chk("down_step_sat",  {7'd0, dn_s}, {7'd0, e.dn});
        chk("lamps_wrap",     lamps_w, e.lw);
        chk("lamps_sat",      lamps_s, e.ls);
      end
    end
  end

  task automatic drive(input bit u, input bit d, input int cycles);
    btn_up   = u;
    btn_down = d;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    btn_up = 1'b0; btn_down = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // count to 5, then reset mid-debounce with up still held
    repeat (5) begin
      drive(1, 0, 10);
      drive(0, 0, 10);
    end
    drive(1, 0, 4);
    rst_n = 1'b0;
    drive(1, 0, 3);
    rst_n = 1'b1;
    drive(1, 0, 30);
    drive(0, 0, 20);

    // clean 30-cycle pulse
    drive(1, 0, 30);
    drive(0, 0, 20);

    // bounce 1-0-1-0 every 2 cycles, then stable
    drive(1, 0, 2); drive(0, 0, 2); drive(1, 0, 2); drive(0, 0, 2);
    drive(1, 0, 12);
    drive(0, 0, 20);

    // reset, then hold down from zero: wrap goes 255,254,...; saturating stays 0
    rst_n = 1'b0;
    drive(0, 0, 2);
    rst_n = 1'b1;
    drive(0, 1, 60);
    drive(0, 0, 20);

    // long up hold drives the saturating copy to its upper bound
    drive(1, 0, 2150);
    drive(0, 0, 20);
    drive(1, 0, 10); drive(0, 0, 10);
    drive(1, 0, 10); drive(0, 0, 10);

    // both buttons in the same cycle cancel
    drive(1, 1, 10);
    drive(0, 0, 20);
    drive(1, 1, 40);
    drive(0, 0, 20);

    // randomized segments with occasional async reset
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        drive(btn_up, btn_down, 2);
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    drive(0, 0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
